// File: rtl/rf_wb_pkg.sv
// Shared widths, defaults and types for the register-file writeback controller.
package rf_wb_pkg;

    localparam int unsigned DATA_W         = 32;
    localparam int unsigned ADDR_W         = 5;
    localparam int unsigned NUM_REGS       = 32;
    localparam int unsigned FIFO_DEPTH_DEF = 4;
    localparam int unsigned CNT_W_DEF      = 3;

    // One pending register write: destination and value.
    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // Where the result written next cycle comes from.
    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_MEM,
        SRC_ALU_Q,
        SRC_ALU_BYP
    } wb_src_e;

endpackage

// File: rtl/rf_wb_fifo.sv
// Synchronous FIFO holding ALU results waiting for the register-file write port.
module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t wdata,
    output wb_entry_t rdata,
    output logic      full,
    output logic      empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == OCC_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap at DEPTH-1 so non-power-of-two depths work too.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_wb_ctrl.sv
// Writeback arbiter: merges load and ALU results onto one register-file write
// port, tracks outstanding writes per register and forwards the in-flight write.
module rf_wb_ctrl
    import rf_wb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rd,
    output logic              iss_ready,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              fwd1_valid,
    output logic [DATA_W-1:0] fwd1_data,
    output logic              fwd2_valid,
    output logic [DATA_W-1:0] fwd2_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_indata
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    wb_entry_t        fifo_head;
    wb_entry_t        alu_entry;
    wb_entry_t        sel_entry;
    wb_src_e          sel_src;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic             alu_accept;
    logic             iss_inc;
    logic             wb_dec;
    logic [CNT_W-1:0] cnt [NUM_REGS];

    assign alu_entry  = '{rd: alu_rd, data: alu_data};
    assign alu_ready  = rst || !fifo_full;
    assign alu_accept = !rst && alu_valid && !fifo_full;

    rf_wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (alu_entry),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Source select: load wins, then queue head; with an empty queue an
    // accepted ALU result cuts straight through instead of being queued.
    always_comb begin
        sel_src   = SRC_NONE;
        sel_entry = '0;
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        if (!rst) begin
            if (mem_valid) begin
                sel_src   = SRC_MEM;
                sel_entry = '{rd: mem_rd, data: mem_data};
                fifo_push = alu_accept;
            end else if (!fifo_empty) begin
                sel_src   = SRC_ALU_Q;
                sel_entry = fifo_head;
                fifo_pop  = 1'b1;
                fifo_push = alu_accept;
            end else if (alu_accept) begin
                sel_src   = SRC_ALU_BYP;
                sel_entry = alu_entry;
            end
        end
    end

    // Register the selected result onto the write port; rd=0 results are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we     <= 1'b0;
            rf_rd     <= '0;
            rf_indata <= '0;
        end else begin
            rf_we <= (sel_src != SRC_NONE) && (sel_entry.rd != '0);
            if (sel_src != SRC_NONE) begin
                rf_rd     <= sel_entry.rd;
                rf_indata <= sel_entry.data;
            end
        end
    end

    assign iss_ready = rst || (iss_rd == '0) || (cnt[iss_rd] != CNT_MAX);
    assign iss_inc   = !rst && iss_valid && (iss_rd != '0) && (cnt[iss_rd] != CNT_MAX);
    assign wb_dec    = rf_we && (cnt[rf_rd] != '0);

    // Pending-write counters: +1 on issue, -1 on writeback, net zero when both hit one register.
    always_ff @(posedge clk) begin
        cnt[0] <= '0;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            if (rst) begin
                cnt[r] <= '0;
            end else if (iss_inc && (iss_rd == ADDR_W'(r)) && !(wb_dec && (rf_rd == ADDR_W'(r)))) begin
                cnt[r] <= cnt[r] + 1'b1;
            end else if (wb_dec && (rf_rd == ADDR_W'(r)) && !(iss_inc && (iss_rd == ADDR_W'(r)))) begin
                cnt[r] <= cnt[r] - 1'b1;
            end
        end
    end

    assign rs1_busy   = !rst && (cnt[rs1] != '0);
    assign rs2_busy   = !rst && (cnt[rs2] != '0);
    assign fwd1_valid = !rst && rf_we && (rf_rd == rs1) && (rs1 != '0);
    assign fwd2_valid = !rst && rf_we && (rf_rd == rs2) && (rs2 != '0);
    assign fwd1_data  = rf_indata;
    assign fwd2_data  = rf_indata;

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Self-checking bench for rf_wb_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a queue/array model of the writeback rules.
module tb_rf_wb_ctrl;

    localparam int DEPTH = 4;
    localparam int CW    = 3;
    localparam int MAXC  = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        iss_ready;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        fwd1_valid;
    logic [31:0] fwd1_data;
    logic        fwd2_valid;
    logic [31:0] fwd2_data;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_indata;

    always #5 clk = ~clk;

    rf_wb_ctrl #(
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .mem_valid  (mem_valid),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .iss_ready  (iss_ready),
        .rs1        (rs1),
        .rs2        (rs2),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy),
        .fwd1_valid (fwd1_valid),
        .fwd1_data  (fwd1_data),
        .fwd2_valid (fwd2_valid),
        .fwd2_data  (fwd2_data),
        .rf_we      (rf_we),
        .rf_rd      (rf_rd),
        .rf_indata  (rf_indata)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: queued ALU results, pending count per register, next write.
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } res_t;

    res_t        q[$];
    int          pend[32];
    bit          m_we;
    int          m_rd;
    logic [31:0] m_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        iss_valid = 1'b0; iss_rd = '0;
        rs1 = '0; rs2 = '0;
    endtask

    task automatic compare_all();
        bit e_ar, e_ir, e_f1, e_f2;
        e_ar = rst || (q.size() < DEPTH);
        e_ir = rst || (iss_rd == 0) || (pend[iss_rd] < MAXC);
        e_f1 = !rst && m_we && (m_rd == int'(rs1)) && (rs1 != 0);
        e_f2 = !rst && m_we && (m_rd == int'(rs2)) && (rs2 != 0);
        chk("alu_ready", alu_ready, e_ar);
        chk("iss_ready", iss_ready, e_ir);
        chk("rf_we", rf_we, m_we);
        if (m_we) begin
            chk("rf_rd", rf_rd, m_rd);
            chk("rf_indata", rf_indata, m_data);
        end
        chk("rs1_busy", rs1_busy, !rst && (pend[rs1] != 0));
        chk("rs2_busy", rs2_busy, !rst && (pend[rs2] != 0));
        chk("fwd1_valid", fwd1_valid, e_f1);
        chk("fwd2_valid", fwd2_valid, e_f2);
        if (e_f1) chk("fwd1_data", fwd1_data, m_data);
        if (e_f2) chk("fwd2_data", fwd2_data, m_data);
    endtask

    // Advance the model by one clock using the inputs held during that cycle.
    task automatic model_edge();
        bit   inc, dec, sel;
        res_t s;
        if (rst) begin
            q.delete();
            foreach (pend[i]) pend[i] = 0;
            m_we = 0; m_rd = 0; m_data = '0;
            return;
        end
        inc = iss_valid && (iss_rd != 0) && (pend[iss_rd] < MAXC);
        dec = m_we && (pend[m_rd] > 0);
        if (alu_valid && (q.size() < DEPTH)) begin
            s.rd = alu_rd; s.data = alu_data;
            q.push_back(s);
        end
        sel = 0;
        s   = '0;
        if (mem_valid) begin
            sel = 1; s.rd = mem_rd; s.data = mem_data;
        end else if (q.size() > 0) begin
            sel = 1; s = q.pop_front();
        end
        if (inc) pend[iss_rd]++;
        if (dec) pend[m_rd]--;
        m_we = sel && (s.rd != 0);
        if (sel) begin
            m_rd = s.rd; m_data = s.data;
        end
    endtask

    task automatic tick();
        #3;
        compare_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int got[$];
        bit was_ready;

        // Reset with garbage on every input; nothing may be taken in.
        idle();
        rst = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h1234;
        mem_valid = 1'b1; mem_rd = 5'd8; mem_data = 32'h5678;
        iss_valid = 1'b1; iss_rd = 5'd7; rs1 = 5'd7; rs2 = 5'd8;
        @(posedge clk);
        model_edge();
        #1;
        tick();
        rst = 1'b0;
        idle();
        rs1 = 5'd7; iss_rd = 5'd7;
        #1;
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_rf_rd", rf_rd, 5'd0);
        chk("rst_rf_indata", rf_indata, 32'd0);
        chk("rst_alu_ready", alu_ready, 1'b1);
        chk("rst_iss_ready", iss_ready, 1'b1);
        chk("rst_busy", rs1_busy, 1'b0);
        chk("rst_fwd", fwd1_valid, 1'b0);
        tick();

        // Single ALU result into an empty queue appears on the port next cycle.
        idle();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        tick();
        idle();
        #1;
        chk("bypass_we", rf_we, 1'b1);
        chk("bypass_rd", rf_rd, 5'd5);
        chk("bypass_data", rf_indata, 32'hDEADBEEF);
        tick();

        // Five ALU pushes under constant load traffic: full after four.
        idle();
        mem_valid = 1'b1; mem_rd = 5'd1; mem_data = 32'h0000_0111;
        alu_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            alu_rd = 5'(10 + i); alu_data = 32'(i);
            #1;
            chk("fill_ready", alu_ready, (i < 4) ? 1'b1 : 1'b0);
            tick();
        end
        mem_valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            was_ready = alu_ready;
            tick();
            if (was_ready) alu_valid = 1'b0;
            if (rf_we && rf_rd >= 5'd10) got.push_back(int'(rf_rd));
        end
        chk("order_count", got.size(), 5);
        for (int i = 0; i < got.size() && i < 5; i++) chk("order_rd", got[i], 10 + i);

        // Load overtakes a queued ALU result.
        idle();
        mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'd99;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'd44;
        tick();
        idle();
        mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'd33;
        tick();
        idle();
        #1;
        chk("prio_first_rd", rf_rd, 5'd3);
        chk("prio_first_data", rf_indata, 32'd33);
        tick();
        chk("prio_second_we", rf_we, 1'b1);
        chk("prio_second_rd", rf_rd, 5'd4);
        chk("prio_second_data", rf_indata, 32'd44);
        tick();

        // Two issues to x7, two writebacks; busy clears only after the second.
        idle();
        iss_valid = 1'b1; iss_rd = 5'd7;
        tick();
        tick();
        idle();
        rs1 = 5'd7;
        #1;
        chk("iss_busy", rs1_busy, 1'b1);
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'd77;
        tick();
        alu_valid = 1'b0;
        #1;
        chk("wb1_fwd_valid", fwd1_valid, 1'b1);
        chk("wb1_fwd_data", fwd1_data, 32'd77);
        tick();
        chk("wb1_busy", rs1_busy, 1'b1);
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'd78;
        tick();
        alu_valid = 1'b0;
        #1;
        chk("wb2_fwd_valid", fwd1_valid, 1'b1);
        chk("wb2_fwd_data", fwd1_data, 32'd78);
        tick();
        chk("wb2_busy", rs1_busy, 1'b0);

        // rd=0 result is consumed but never written.
        idle();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'd1;
        #1;
        chk("rd0_ready", alu_ready, 1'b1);
        tick();
        idle();
        #1;
        chk("rd0_we_a", rf_we, 1'b0);
        tick();
        chk("rd0_we_b", rf_we, 1'b0);

        // Reset with three queued entries and a pending issue drops everything.
        idle();
        mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'd22;
        alu_valid = 1'b1; iss_valid = 1'b1; iss_rd = 5'd20;
        for (int i = 0; i < 3; i++) begin
            alu_rd = 5'(20 + i); alu_data = 32'(200 + i);
            tick();
        end
        idle();
        rs1 = 5'd20;
        #1;
        chk("pre_rst_busy", rs1_busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_ready", alu_ready, 1'b1);
        chk("post_rst_busy", rs1_busy, 1'b0);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("post_rst_we", rf_we, 1'b0);
        end

        // Randomized traffic, small register range to hit saturation and forwarding.
        for (int c = 0; c < 2000; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            alu_valid = ($urandom_range(0, 9) < 6);
            alu_rd    = 5'($urandom_range(0, 7));
            alu_data  = $urandom;
            mem_valid = ($urandom_range(0, 3) == 0);
            mem_rd    = 5'($urandom_range(0, 7));
            mem_data  = $urandom;
            iss_valid = ($urandom_range(0, 1) == 1);
            iss_rd    = 5'($urandom_range(0, 7));
            rs1       = 5'($urandom_range(0, 7));
            rs2       = 5'($urandom_range(0, 7));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
